// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the intersection signal controllers: phase
//   encodings, the seconds-field width and helper functions for approach
//   selection and duration loading.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int SEC_W     = 8;
    // Upper bound on approaches the search helper can handle.
    localparam int MAX_DIR   = 32;
    localparam int MAX_DIR_W = 5;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_CLEAR  = 2'd3
    } phase_e;

    // Round-robin search: first set bit of req at or after start (wrapping
    // within num_dir). Returns -1 when no bit is set.
    function automatic int next_req_idx(input logic [MAX_DIR-1:0] req,
                                        input int num_dir,
                                        input int start);
        int idx;
        int found;
        found = -1;
        for (int i = 0; i < MAX_DIR; i++) begin
            idx = (start + i) % num_dir;
            if ((i < num_dir) && (found < 0) && req[idx[MAX_DIR_W-1:0]]) begin
                found = idx;
            end else begin
                found = found;
            end
        end
        return found;
    endfunction

    // A programmed duration of zero is served as one second.
    function automatic logic [SEC_W-1:0] dur_load(input logic [SEC_W-1:0] sec);
        return (sec == {SEC_W{1'b0}}) ? SEC_W'(1) : sec;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
//   Seconds prescaler: tick_o pulses for one clk cycle every TICK_DIV cycles.
//   clr_i restarts the count so the first tick after a clear lands exactly
//   TICK_DIV cycles later.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr_i     synchronous restart of the prescaler
//   tick_o    one-cycle tick pulse
// -----------------------------------------------------------------------------
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_s;

    assign wrap_s = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_o = wrap_s;

    // Next prescaler value: restart on clear or at the end of a second.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_dir_signal_controller.sv
// -----------------------------------------------------------------------------
// multi_dir_signal_controller
//   N-approach intersection signal controller. Serves approaches round-robin
//   (fixed or demand-actuated) or holds a manually selected approach green.
//   Every change away from green goes through timed yellow and timed all-red.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mode_manual, actuated_en  mode controls
//   demand, manual_sel        per-approach detector / manual request
//   green_sec, yellow_sec, allred_sec  phase durations in seconds
//   red_o, yellow_o, green_o  registered per-approach lamps
//   countdown_sec             remaining seconds of a timed phase (0 untimed)
//   active_dir                approach currently or last served
//   phase                     0=IDLE 1=GREEN 2=YELLOW 3=CLEAR
// -----------------------------------------------------------------------------
module multi_dir_signal_controller
    import traffic_pkg::*;
#(
    parameter int NUM_DIR  = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int DIR_W    = $clog2(NUM_DIR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_manual,
    input  logic               actuated_en,
    input  logic [NUM_DIR-1:0] demand,
    input  logic [NUM_DIR-1:0] manual_sel,
    input  logic [SEC_W-1:0]   green_sec,
    input  logic [SEC_W-1:0]   yellow_sec,
    input  logic [SEC_W-1:0]   allred_sec,
    output logic [NUM_DIR-1:0] red_o,
    output logic [NUM_DIR-1:0] yellow_o,
    output logic [NUM_DIR-1:0] green_o,
    output logic [SEC_W-1:0]   countdown_sec,
    output logic [DIR_W-1:0]   active_dir,
    output logic [1:0]         phase
);

    localparam logic [NUM_DIR-1:0] ONE_OH = {{(NUM_DIR-1){1'b0}}, 1'b1};

    phase_e             phase_q, phase_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [SEC_W-1:0]   cnt_q, cnt_d;
    logic               hold_q, hold_d;      // green is an untimed manual hold
    logic [NUM_DIR-1:0] red_q, red_d;
    logic [NUM_DIR-1:0] yel_q, yel_d;
    logic [NUM_DIR-1:0] grn_q, grn_d;

    logic               tick_s;
    logic               load_s;              // restart the prescaler this cycle
    logic               expire_s;
    logic [NUM_DIR-1:0] dir_oh_s;
    logic [NUM_DIR-1:0] dir_oh_d_s;
    logic [DIR_W-1:0]   man_idx_s;
    logic [DIR_W-1:0]   fix_idx_s;
    int                 act_idx_s;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (load_s),
        .tick_o (tick_s)
    );

    assign dir_oh_s   = ONE_OH << dir_q;
    assign dir_oh_d_s = ONE_OH << dir_d;
    assign expire_s   = tick_s && (cnt_q == SEC_W'(1));
    assign fix_idx_s  = (dir_q == DIR_W'(NUM_DIR - 1)) ? {DIR_W{1'b0}} : dir_q + DIR_W'(1);
    assign act_idx_s  = next_req_idx(MAX_DIR'(demand), NUM_DIR, int'(dir_q) + 1);

    // Index of the manually requested approach (meaningful only when one-hot).
    always_comb begin
        man_idx_s = {DIR_W{1'b0}};
        for (int i = 0; i < NUM_DIR; i++) begin
            man_idx_s = manual_sel[i] ? DIR_W'(i) : man_idx_s;
        end
    end

    // Phase sequencing, countdown and served-approach selection.
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        load_s  = 1'b0;
        cnt_d   = (tick_s && (cnt_q != {SEC_W{1'b0}})) ? cnt_q - SEC_W'(1) : cnt_q;
        case (phase_q)
            PH_IDLE: begin
                cnt_d = {SEC_W{1'b0}};
                if (mode_manual) begin
                    if ($onehot(manual_sel)) begin
                        phase_d = PH_GREEN;
                        dir_d   = man_idx_s;
                        hold_d  = 1'b1;
                        load_s  = 1'b1;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end else if (actuated_en) begin
                    if (act_idx_s >= 0) begin
                        phase_d = PH_GREEN;
                        dir_d   = DIR_W'(act_idx_s);
                        hold_d  = 1'b0;
                        cnt_d   = dur_load(green_sec);
                        load_s  = 1'b1;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end else begin
                    phase_d = PH_GREEN;
                    dir_d   = fix_idx_s;
                    hold_d  = 1'b0;
                    cnt_d   = dur_load(green_sec);
                    load_s  = 1'b1;
                end
            end
            PH_GREEN: begin
                // Mode/selection changes are checked before expiry so they win.
                if (hold_q) begin
                    cnt_d = {SEC_W{1'b0}};
                    if (!mode_manual || (manual_sel != dir_oh_s)) begin
                        phase_d = PH_YELLOW;
                        hold_d  = 1'b0;
                        cnt_d   = dur_load(yellow_sec);
                        load_s  = 1'b1;
                    end else begin
                        phase_d = PH_GREEN;
                    end
                end else if (mode_manual) begin
                    if (manual_sel == dir_oh_s) begin
                        hold_d = 1'b1;
                        cnt_d  = {SEC_W{1'b0}};
                    end else begin
                        phase_d = PH_YELLOW;
                        cnt_d   = dur_load(yellow_sec);
                        load_s  = 1'b1;
                    end
                end else if (expire_s) begin
                    // Actuated: keep green while nobody else is waiting.
                    if (actuated_en && ((demand & ~dir_oh_s) == {NUM_DIR{1'b0}})) begin
                        cnt_d  = dur_load(green_sec);
                        load_s = 1'b1;
                    end else begin
                        phase_d = PH_YELLOW;
                        cnt_d   = dur_load(yellow_sec);
                        load_s  = 1'b1;
                    end
                end else begin
                    phase_d = PH_GREEN;
                end
            end
            PH_YELLOW: begin
                if (expire_s) begin
                    phase_d = PH_CLEAR;
                    cnt_d   = dur_load(allred_sec);
                    load_s  = 1'b1;
                end else begin
                    phase_d = PH_YELLOW;
                end
            end
            PH_CLEAR: begin
                if (expire_s) begin
                    phase_d = PH_IDLE;
                    cnt_d   = {SEC_W{1'b0}};
                end else begin
                    phase_d = PH_CLEAR;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                hold_d  = 1'b0;
                cnt_d   = {SEC_W{1'b0}};
            end
        endcase
    end

    // Lamp decode from the next phase so lamps change with phase/active_dir.
    always_comb begin
        red_d = {NUM_DIR{1'b1}};
        yel_d = {NUM_DIR{1'b0}};
        grn_d = {NUM_DIR{1'b0}};
        case (phase_d)
            PH_GREEN: begin
                red_d = ~dir_oh_d_s;
                grn_d = dir_oh_d_s;
            end
            PH_YELLOW: begin
                red_d = ~dir_oh_d_s;
                yel_d = dir_oh_d_s;
            end
            default: begin
                red_d = {NUM_DIR{1'b1}};
            end
        endcase
    end

    // State, countdown and lamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            dir_q   <= DIR_W'(NUM_DIR - 1);
            cnt_q   <= {SEC_W{1'b0}};
            hold_q  <= 1'b0;
            red_q   <= {NUM_DIR{1'b1}};
            yel_q   <= {NUM_DIR{1'b0}};
            grn_q   <= {NUM_DIR{1'b0}};
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
        end
    end

    assign red_o         = red_q;
    assign yellow_o      = yel_q;
    assign green_o       = grn_q;
    assign countdown_sec = cnt_q;
    assign active_dir    = dir_q;
    assign phase         = phase_q;

endmodule
